traffic_sensor_arbiter: RTL and testbench

Upstream conditioning stage for a two-way intersection built from two traffic_fsm instances (direction A, direction B). It synchronises and debounces the raw vehicle sensors for each direction into clean T signals. It also maintains the mutually exclusive round-robin priority bits that each FSM uses to break Tself/Tother conflicts. It observes both light outputs to decide when priority has been served and must rotate.

---
 rtl/traffic_sensor_arbiter_if.sv | 27 ++
 rtl/traffic_sensor_arbiter.sv | 114 +++++++++++
 tb/tb_traffic_sensor_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_sensor_arbiter_if.sv
// rtl/traffic_sensor_arbiter_if.sv - sensor/light/priority bundle between intersection control and the arbiter
// Ports:
//   sensor_a_raw, sensor_b_raw : raw asynchronous vehicle sensors
//   light_a, light_b           : light state from each direction FSM (10 red, 01 yellow, 00 green, 11 red)
//   t_a, t_b                   : debounced vehicle-present flags
//   prio_a, prio_b             : mutually exclusive priority bits
// master drives sensors/lights and observes results; slave is the arbiter.
interface traffic_sensor_arbiter_if;
  logic       sensor_a_raw;
  logic       sensor_b_raw;
  logic [1:0] light_a;
  logic [1:0] light_b;
  logic       t_a;
  logic       t_b;
  logic       prio_a;
  logic       prio_b;

  modport master (
    output sensor_a_raw, sensor_b_raw, light_a, light_b,
    input  t_a, t_b, prio_a, prio_b
  );

  modport slave (
    input  sensor_a_raw, sensor_b_raw, light_a, light_b,
    output t_a, t_b, prio_a, prio_b
  );
endinterface

// File: rtl/traffic_sensor_arbiter.sv
// rtl/traffic_sensor_arbiter.sv - sensor synchroniser/debouncer and round-robin priority for two traffic FSMs
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : traffic_sensor_arbiter_if.slave (sensors and lights in, t_a/t_b/prio_a/prio_b out)
module traffic_sensor_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                     clk,
  input  logic                     rst,
  traffic_sensor_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is direction A, channel 1 is direction B.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       t;
  logic [CNT_W-1:0] cnt [2];

  assign raw = {bus.sensor_b_raw, bus.sensor_a_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      t  <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        // Any return to the current level clears the count, so a glitch
        // shorter than DEBOUNCE_CYCLES never accumulates across pulses.
        if (s2[i] == t[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          t[i]   <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign bus.t_a = t[0];
  assign bus.t_b = t[1];

  // Previous lights reset to red so a green present at reset release
  // counts as a fresh green.
  logic [1:0] prev_a;
  logic [1:0] prev_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a <= 2'b10;
      prev_b <= 2'b10;
    end else begin
      prev_a <= bus.light_a;
      prev_b <= bus.light_b;
    end
  end

  // 11 is not 00, so 11 -> 00 is a rising green like 10 -> 00.
  logic served_a;
  logic served_b;
  logic handover_a;
  logic handover_b;

  assign served_a   = (bus.light_a == 2'b00) && (prev_a != 2'b00);
  assign served_b   = (bus.light_b == 2'b00) && (prev_b != 2'b00);
  // Holder has no demand, the other side does, and the holder is not green.
  assign handover_a = !t[0] && t[1] && (bus.light_a != 2'b00);
  assign handover_b = !t[1] && t[0] && (bus.light_b != 2'b00);

  typedef enum logic {PRIO_A, PRIO_B} prio_state_t;
  prio_state_t state;
  logic        prio_a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PRIO_A;
      prio_a_q <= 1'b1;
    end else begin
      case (state)
        PRIO_A: begin
          if (served_a || handover_a) begin
            state    <= PRIO_B;
            prio_a_q <= 1'b0;
          end
        end
        PRIO_B: begin
          if (served_b || handover_b) begin
            state    <= PRIO_A;
            prio_a_q <= 1'b1;
          end
        end
        default: begin
          state    <= PRIO_A;
          prio_a_q <= 1'b1;
        end
      endcase
    end
  end

  // Both bits come from one flop, so they can never be equal.
  assign bus.prio_a = prio_a_q;
  assign bus.prio_b = ~prio_a_q;

endmodule

// File: tb/tb_traffic_sensor_arbiter.sv
// tb/tb_traffic_sensor_arbiter.sv - directed self-checking bench for traffic_sensor_arbiter
module tb_traffic_sensor_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  traffic_sensor_arbiter_if bus ();

  traffic_sensor_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs set after this are sampled by the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.sensor_a_raw = 1'b0;
    bus.sensor_b_raw = 1'b0;
    bus.light_a = 2'b10;
    bus.light_b = 2'b10;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++; if (bus.t_a !== 1'b0) begin fails++; $display("FAIL reset_t_a got %b want 0", bus.t_a); end
    tests++; if (bus.t_b !== 1'b0) begin fails++; $display("FAIL reset_t_b got %b want 0", bus.t_b); end
    tests++; if (bus.prio_a !== 1'b1) begin fails++; $display("FAIL reset_prio_a got %b want 1", bus.prio_a); end
    tests++; if (bus.prio_b !== 1'b0) begin fails++; $display("FAIL reset_prio_b got %b want 0", bus.prio_b); end
  endtask

  task automatic test_debounce_latency();
    bus.sensor_a_raw = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      step();
      tests++;
      if (bus.t_a !== (e >= 5 ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL latency_t_a edge %0d got %b want %b", e, bus.t_a, (e >= 5));
      end
    end
    tests++; if (bus.t_b !== 1'b0) begin fails++; $display("FAIL latency_t_b got %b want 0", bus.t_b); end
    tests++; if (bus.prio_a !== 1'b1 || bus.prio_b !== 1'b0) begin
      fails++; $display("FAIL latency_prio got %b%b want 10", bus.prio_a, bus.prio_b);
    end
  endtask

  task automatic test_glitch();
    int rise_e;
    int fall_e;
    bus.sensor_a_raw = 1'b0;
    for (int i = 0; i < 7; i++) step();
    tests++; if (bus.t_a !== 1'b0) begin fails++; $display("FAIL glitch_setup got %b want 0", bus.t_a); end
    // 3-cycle pulse must be rejected.
    bus.sensor_a_raw = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.sensor_a_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (bus.t_a !== 1'b0) begin fails++; $display("FAIL glitch_short step %0d got %b want 0", i, bus.t_a); end
      step();
    end
    // 4-cycle pulse: rise at edge 5, fall 5 edges after low is sampled (edge 9).
    rise_e = -1;
    fall_e = -1;
    bus.sensor_a_raw = 1'b1;
    for (int e = 0; e < 15; e++) begin
      step();
      if (e == 3) bus.sensor_a_raw = 1'b0;
      if (bus.t_a === 1'b1 && rise_e < 0) rise_e = e;
      if (bus.t_a === 1'b0 && rise_e >= 0 && fall_e < 0) fall_e = e;
    end
    tests++; if (rise_e != 5) begin fails++; $display("FAIL glitch_rise_edge got %0d want 5", rise_e); end
    tests++; if (fall_e != 9) begin fails++; $display("FAIL glitch_fall_edge got %0d want 9", fall_e); end
  endtask

  task automatic test_served_rotation();
    bus.sensor_a_raw = 1'b1;
    bus.sensor_b_raw = 1'b1;
    for (int i = 0; i < 7; i++) step();
    tests++; if (bus.t_a !== 1'b1 || bus.t_b !== 1'b1) begin
      fails++; $display("FAIL served_setup got t=%b%b want 11", bus.t_a, bus.t_b);
    end
    tests++; if (bus.prio_a !== 1'b1) begin fails++; $display("FAIL served_pre got %b want 1", bus.prio_a); end
    bus.light_a = 2'b00;
    step();
    tests++; if (bus.prio_a !== 1'b0 || bus.prio_b !== 1'b1) begin
      fails++; $display("FAIL served_toggle got %b%b want 01", bus.prio_a, bus.prio_b);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (bus.prio_a !== 1'b0) begin fails++; $display("FAIL served_hold step %0d got %b want 0", i, bus.prio_a); end
    end
    bus.light_a = 2'b10;
    // B going green while it holds priority hands it back to A.
    bus.light_b = 2'b00;
    step();
    bus.light_b = 2'b10;
    tests++; if (bus.prio_a !== 1'b1) begin fails++; $display("FAIL served_b_back got %b want 1", bus.prio_a); end
  endtask

  task automatic test_idle_handover();
    int n;
    bus.sensor_a_raw = 1'b0;
    n = 0;
    while (bus.t_a !== 1'b0 && n < 20) begin step(); n++; end
    tests++; if (bus.t_a !== 1'b0) begin fails++; $display("FAIL handover_wait_a t_a got %b want 0", bus.t_a); end
    tests++; if (bus.prio_a !== 1'b1) begin fails++; $display("FAIL handover_pre got %b want 1", bus.prio_a); end
    step();
    tests++; if (bus.prio_b !== 1'b1 || bus.prio_a !== 1'b0) begin
      fails++; $display("FAIL handover_to_b got %b%b want 01", bus.prio_a, bus.prio_b);
    end
    bus.sensor_a_raw = 1'b1;
    bus.sensor_b_raw = 1'b0;
    n = 0;
    while (bus.t_a !== 1'b1 && n < 20) begin step(); n++; end
    tests++; if (bus.t_a !== 1'b1 || bus.t_b !== 1'b0) begin
      fails++; $display("FAIL handover_wait_b got t=%b%b want 10", bus.t_a, bus.t_b);
    end
    tests++; if (bus.prio_a !== 1'b0) begin fails++; $display("FAIL handover_back_pre got %b want 0", bus.prio_a); end
    step();
    tests++; if (bus.prio_a !== 1'b1 || bus.prio_b !== 1'b0) begin
      fails++; $display("FAIL handover_to_a got %b%b want 10", bus.prio_a, bus.prio_b);
    end
  endtask

  task automatic test_non_holder_and_11();
    bus.light_b = 2'b00;
    step();
    tests++; if (bus.prio_a !== 1'b1) begin fails++; $display("FAIL nonholder_green got %b want 1", bus.prio_a); end
    step();
    tests++; if (bus.prio_a !== 1'b1) begin fails++; $display("FAIL nonholder_hold got %b want 1", bus.prio_a); end
    // light_b stays 00 so B cannot hand priority straight back.
    bus.light_a = 2'b11;
    step();
    tests++; if (bus.prio_a !== 1'b1) begin fails++; $display("FAIL light11_hold got %b want 1", bus.prio_a); end
    bus.light_a = 2'b00;
    step();
    tests++; if (bus.prio_a !== 1'b0 || bus.prio_b !== 1'b1) begin
      fails++; $display("FAIL light11_served got %b%b want 01", bus.prio_a, bus.prio_b);
    end
  endtask

  task automatic test_reset_mid_debounce();
    bus.sensor_b_raw = 1'b1;
    for (int i = 0; i < 4; i++) step();
    tests++; if (bus.t_b !== 1'b0 || bus.prio_b !== 1'b1) begin
      fails++; $display("FAIL midrst_pre got t_b=%b prio_b=%b want 0 1", bus.t_b, bus.prio_b);
    end
    rst = 1'b1;
    bus.light_a = 2'b10;
    bus.light_b = 2'b10;
    step();
    rst = 1'b0;
    tests++; if (bus.t_a !== 1'b0 || bus.t_b !== 1'b0) begin
      fails++; $display("FAIL midrst_t got %b%b want 00", bus.t_a, bus.t_b);
    end
    tests++; if (bus.prio_a !== 1'b1 || bus.prio_b !== 1'b0) begin
      fails++; $display("FAIL midrst_prio got %b%b want 10", bus.prio_a, bus.prio_b);
    end
    for (int e = 0; e <= 5; e++) begin
      step();
      tests++;
      if (bus.t_b !== (e >= 5 ? 1'b1 : 1'b0) || bus.t_a !== (e >= 5 ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL midrst_redebounce edge %0d got %b%b want %b%b", e, bus.t_a, bus.t_b, (e >= 5), (e >= 5));
      end
    end
    tests++; if (bus.prio_a !== 1'b1) begin fails++; $display("FAIL midrst_prio_after got %b want 1", bus.prio_a); end
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_served_rotation();
    test_idle_handover();
    test_non_holder_and_11();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
